// File: rtl/seven_seg_scanner_pkg.sv
// Shared definitions for the seven-segment scanner: nibble width, the glyph
// type and the active-low segment patterns (bit0=a .. bit6=g, 0 = segment lit).
// Ports: none (package).
package seg_pkg;

  localparam int DIGIT_W = 4;

  typedef logic [6:0] seg_t;

  // All segments dark.
  localparam seg_t SEG_BLANK = 7'h7F;

  // Decimal glyphs.
  localparam seg_t SEG_0 = 7'h40;
  localparam seg_t SEG_1 = 7'h79;
  localparam seg_t SEG_2 = 7'h24;
  localparam seg_t SEG_3 = 7'h30;
  localparam seg_t SEG_4 = 7'h19;
  localparam seg_t SEG_5 = 7'h12;
  localparam seg_t SEG_6 = 7'h02;
  localparam seg_t SEG_7 = 7'h78;
  localparam seg_t SEG_8 = 7'h00;
  localparam seg_t SEG_9 = 7'h10;

  // Hex glyphs; b and d are lower case so they stay distinct from 8 and 0.
  localparam seg_t SEG_A = 7'h08;
  localparam seg_t SEG_B = 7'h03;
  localparam seg_t SEG_C = 7'h46;
  localparam seg_t SEG_D = 7'h21;
  localparam seg_t SEG_E = 7'h06;
  localparam seg_t SEG_F = 7'h0E;

endpackage

// File: rtl/seven_seg_scanner_if.sv
// Display-side bundle for the scanner: load strobe with value/decimal points,
// blank control in one direction, segment/anode pins and frame pulse back.
// Ports: master = datapath/board side, slave = scanner.
interface seven_seg_scanner_if #(
  parameter int NUM_DIGITS = 4
);

  logic                      load;
  logic [4*NUM_DIGITS-1:0]   value;
  logic [NUM_DIGITS-1:0]     dp_in;
  logic                      blank;
  logic [6:0]                segments;
  logic                      dp_n;
  logic [NUM_DIGITS-1:0]     anode_n;
  logic                      frame_done;

  modport master (
    output load, value, dp_in, blank,
    input  segments, dp_n, anode_n, frame_done
  );

  modport slave (
    input  load, value, dp_in, blank,
    output segments, dp_n, anode_n, frame_done
  );

endinterface

// File: rtl/seven_seg_scanner_glyph.sv
// Combinational nibble to active-low seven-segment glyph.
// Ports: nibble (4b digit), hex_en (show A..F, else 10..15 go dark), glyph (7b, bit0=a).
module seg_glyph_encoder
  import seg_pkg::*;
(
  input  logic [DIGIT_W-1:0] nibble,
  input  logic               hex_en,
  output seg_t               glyph
);

  always_comb begin
    glyph = SEG_BLANK;
    unique case (nibble)
      4'h0: glyph = SEG_0;
      4'h1: glyph = SEG_1;
      4'h2: glyph = SEG_2;
      4'h3: glyph = SEG_3;
      4'h4: glyph = SEG_4;
      4'h5: glyph = SEG_5;
      4'h6: glyph = SEG_6;
      4'h7: glyph = SEG_7;
      4'h8: glyph = SEG_8;
      4'h9: glyph = SEG_9;
      4'hA: glyph = hex_en ? SEG_A : SEG_BLANK;
      4'hB: glyph = hex_en ? SEG_B : SEG_BLANK;
      4'hC: glyph = hex_en ? SEG_C : SEG_BLANK;
      4'hD: glyph = hex_en ? SEG_D : SEG_BLANK;
      4'hE: glyph = hex_en ? SEG_E : SEG_BLANK;
      4'hF: glyph = hex_en ? SEG_F : SEG_BLANK;
      default: glyph = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode 7-segment driver: one digit per refresh slot,
// double-buffered value (pending -> active at frame wrap), leading-zero blanking.
// Ports: clk, rst (sync, active-high), bus (slave: load/value/dp_in/blank in; segments/dp_n/anode_n/frame_done out).
module seven_seg_scanner
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 2,
  parameter int HEX_MODE    = 0,
  parameter int LZ_SUPPRESS = 1
) (
  input  logic                clk,
  input  logic                rst,
  seven_seg_scanner_if.slave  bus
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS  > 1) ? $clog2(NUM_DIGITS)  : 1;
  localparam int VAL_W = DIGIT_W * NUM_DIGITS;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // Scan state.
  logic [DIV_W-1:0]      div_cnt;
  logic [IDX_W-1:0]      idx;

  // Double buffer: loads land in pending, the scan only ever reads active.
  logic [VAL_W-1:0]      act_val;
  logic [NUM_DIGITS-1:0] act_dp;
  logic [VAL_W-1:0]      pend_val;
  logic [NUM_DIGITS-1:0] pend_dp;
  logic                  pend_v;

  // Registered pin drivers.
  seg_t                  seg_q;
  logic                  dp_n_q;
  logic [NUM_DIGITS-1:0] anode_q;
  logic                  frame_done_q;

  logic                  slot_end;
  logic                  wrap;
  logic                  in_guard;
  logic [DIGIT_W-1:0]    cur_nib;
  logic                  cur_dp;
  logic                  cur_sup;
  logic                  dark;
  seg_t                  cur_glyph;
  logic [NUM_DIGITS-1:0] sup_mask;
  logic                  zero_run;
  logic [NUM_DIGITS-1:0] idx_onehot;

  assign slot_end = (div_cnt == DIV_LAST);
  assign wrap     = slot_end && (idx == IDX_LAST);
  assign in_guard = (int'(div_cnt) < GUARD);

  assign cur_nib  = act_val[int'(idx)*DIGIT_W +: DIGIT_W];
  assign cur_dp   = act_dp[idx];
  assign cur_sup  = sup_mask[idx];

  // A suppressed digit shows nothing at all, blank kills the whole display.
  assign dark     = bus.blank || cur_sup;

  // Walk from the most significant digit down: a digit stays suppressed only
  // while every nibble at or above it is zero and none of them carries a dp.
  // Digit 0 always shows, so a zero value still reads "0".
  always_comb begin
    sup_mask = '0;
    zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run && (act_val[k*DIGIT_W +: DIGIT_W] == '0) && !act_dp[k];
      if ((LZ_SUPPRESS != 0) && (k > 0)) begin
        sup_mask[k] = zero_run;
      end
    end
  end

  always_comb begin
    idx_onehot      = '0;
    idx_onehot[idx] = 1'b1;
  end

  seg_glyph_encoder u_glyph (
    .nibble (cur_nib),
    .hex_en (HEX_MODE != 0),
    .glyph  (cur_glyph)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt      <= '0;
      idx          <= '0;
      act_val      <= '0;
      act_dp       <= '0;
      pend_val     <= '0;
      pend_dp      <= '0;
      pend_v       <= 1'b0;
      seg_q        <= SEG_BLANK;
      dp_n_q       <= 1'b1;
      anode_q      <= '1;
      frame_done_q <= 1'b0;
    end else begin
      // Refresh divider and digit index.
      if (slot_end) begin
        div_cnt <= '0;
        idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      frame_done_q <= wrap;

      // Buffer update. The frame boundary is the only place active changes,
      // so a frame never mixes old and new digits. A load on the boundary
      // itself bypasses pending and supersedes anything parked there.
      if (wrap) begin
        if (bus.load) begin
          act_val <= bus.value;
          act_dp  <= bus.dp_in;
        end else if (pend_v) begin
          act_val <= pend_val;
          act_dp  <= pend_dp;
        end
        pend_v <= 1'b0;
      end else if (bus.load) begin
        pend_val <= bus.value;
        pend_dp  <= bus.dp_in;
        pend_v   <= 1'b1;
      end

      // Pins. Segments keep showing the glyph during the guard window; the
      // anodes being off is what prevents ghosting from the previous digit.
      anode_q <= (in_guard || dark) ? '1 : ~idx_onehot;
      seg_q   <= dark ? SEG_BLANK : cur_glyph;
      dp_n_q  <= dark ? 1'b1 : ~cur_dp;
    end
  end

  assign bus.segments   = seg_q;
  assign bus.dp_n       = dp_n_q;
  assign bus.anode_n    = anode_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with NUM_DIGITS=4, REFRESH_DIV=4, GUARD=1.
// Two instances run in lockstep: u0 (HEX_MODE=0, LZ_SUPPRESS=0), u1 (HEX_MODE=1, LZ_SUPPRESS=1).
module tb_seven_seg_scanner;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_err    = 0;

  // cyc is the bench's own view of the scan position: after step() with
  // cyc = c the pins show div_cnt = c%4 and idx = (c/4)%4.
  int cyc   = -1;
  bit track = 1'b0;

  always #5 clk = ~clk;

  seven_seg_scanner_if #(.NUM_DIGITS(4)) if0 ();
  seven_seg_scanner_if #(.NUM_DIGITS(4)) if1 ();

  seven_seg_scanner #(
    .NUM_DIGITS(4), .REFRESH_DIV(4), .GUARD(1), .HEX_MODE(0), .LZ_SUPPRESS(0)
  ) u0 (
    .clk (clk),
    .rst (rst),
    .bus (if0.slave)
  );

  seven_seg_scanner #(
    .NUM_DIGITS(4), .REFRESH_DIV(4), .GUARD(1), .HEX_MODE(1), .LZ_SUPPRESS(1)
  ) u1 (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic [15:0] v, input logic [3:0] dp, input logic bl);
    if0.load = ld; if0.value = v; if0.dp_in = dp; if0.blank = bl;
    if1.load = ld; if1.value = v; if1.dp_in = dp; if1.blank = bl;
  endtask

  // One clock; also checks the frame pulse and the guard window every cycle.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (track) begin
      chk($sformatf("frame_done0@%0d", cyc), 32'(if0.frame_done), 32'(cyc % 16 == 15));
      chk($sformatf("frame_done1@%0d", cyc), 32'(if1.frame_done), 32'(cyc % 16 == 15));
      if (cyc % 4 == 0) begin
        chk($sformatf("guard0@%0d", cyc), 32'(if0.anode_n), 32'hF);
        chk($sformatf("guard1@%0d", cyc), 32'(if1.anode_n), 32'hF);
      end
    end
  endtask

  // Advance at least one cycle, stopping at the next cycle with cyc%16 == m.
  task automatic goto(input int m);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while ((cyc % 16 != m) && (n < 20));
  endtask

  // Drive a load so that it is sampled on the edge after scan position m.
  task automatic load_at(input int m, input logic [15:0] v, input logic [3:0] dp);
    goto(m);
    drive(1'b1, v, dp, 1'b0);
    step();
    drive(1'b0, 16'h0000, 4'h0, 1'b0);
  endtask

  // Check the middle of each digit slot of the next frame.
  // s*: glyphs digit3..digit0, l*: 1 = anode lit, d*: expected dp_n per digit.
  task automatic frame_check(input string tag,
                             input logic [27:0] s0, input logic [3:0] l0, input logic [3:0] d0,
                             input logic [27:0] s1, input logic [3:0] l1, input logic [3:0] d1);
    logic [3:0] an0;
    logic [3:0] an1;
    for (int k = 0; k < 4; k++) begin
      goto(4 * k + 2);
      an0 = 4'hF;
      an1 = 4'hF;
      if (l0[k]) an0[k] = 1'b0;
      if (l1[k]) an1[k] = 1'b0;
      chk($sformatf("%s.an0[%0d]", tag, k),  32'(if0.anode_n),  32'(an0));
      chk($sformatf("%s.seg0[%0d]", tag, k), 32'(if0.segments), 32'(s0[k*7 +: 7]));
      chk($sformatf("%s.dp0[%0d]", tag, k),  32'(if0.dp_n),     32'(d0[k]));
      chk($sformatf("%s.an1[%0d]", tag, k),  32'(if1.anode_n),  32'(an1));
      chk($sformatf("%s.seg1[%0d]", tag, k), 32'(if1.segments), 32'(s1[k*7 +: 7]));
      chk($sformatf("%s.dp1[%0d]", tag, k),  32'(if1.dp_n),     32'(d1[k]));
    end
  endtask

  task automatic reset_outputs(input string tag);
    chk({tag, ".seg0"}, 32'(if0.segments),   32'h7F);
    chk({tag, ".dp0"},  32'(if0.dp_n),       32'h1);
    chk({tag, ".an0"},  32'(if0.anode_n),    32'hF);
    chk({tag, ".fd0"},  32'(if0.frame_done), 32'h0);
    chk({tag, ".seg1"}, 32'(if1.segments),   32'h7F);
    chk({tag, ".dp1"},  32'(if1.dp_n),       32'h1);
    chk({tag, ".an1"},  32'(if1.anode_n),    32'hF);
    chk({tag, ".fd1"},  32'(if1.frame_done), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 16'h0000, 4'h0, 1'b0);

    // 1. Reset held three cycles, then released.
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    cyc = -1;
    track = 1'b1;
    reset_outputs("reset");
    step();                                  // guard of digit 0
    chk("first_guard.an0", 32'(if0.anode_n), 32'hF);
    step();                                  // digit 0 lit, active value is 0
    chk("first_lit.an0",  32'(if0.anode_n),  32'hE);
    chk("first_lit.an1",  32'(if1.anode_n),  32'hE);
    chk("first_lit.seg0", 32'(if0.segments), 32'h40);
    chk("first_lit.seg1", 32'(if1.segments), 32'h40);

    // 2. 1234 loaded mid-frame: current frame untouched, next frame shows it.
    drive(1'b1, 16'h1234, 4'h0, 1'b0);
    step();
    drive(1'b0, 16'h0000, 4'h0, 1'b0);
    chk("no_tear.seg0", 32'(if0.segments), 32'h40);
    chk("no_tear.an0",  32'(if0.anode_n),  32'hE);
    frame_check("v1234",
                {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 4'hF,
                {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 4'hF);

    // 3. ABCD: hex glyphs on u1, dark but still scanned on u0.
    load_at(3, 16'hABCD, 4'h0);
    frame_check("vABCD",
                {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'hF, 4'hF,
                {7'h08, 7'h03, 7'h46, 7'h21}, 4'hF, 4'hF);

    // 4. Leading zeros, then a dp on digit 2 re-enables digits 1..2.
    load_at(3, 16'h0007, 4'h0);
    frame_check("v0007",
                {7'h40, 7'h40, 7'h40, 7'h78}, 4'hF, 4'hF,
                {7'h7F, 7'h7F, 7'h7F, 7'h78}, 4'h1, 4'hF);
    load_at(3, 16'h0007, 4'b0100);
    frame_check("v0007dp",
                {7'h40, 7'h40, 7'h40, 7'h78}, 4'hF, 4'b1011,
                {7'h7F, 7'h40, 7'h40, 7'h78}, 4'h7, 4'b1011);

    // 5. Two loads inside one frame: last wins, applied only at the wrap.
    load_at(5, 16'h1111, 4'h0);
    load_at(9, 16'h2222, 4'h0);
    chk("pend_hold.an0",  32'(if0.anode_n),  32'hB);
    chk("pend_hold.seg0", 32'(if0.segments), 32'h40);
    chk("pend_hold.dp0",  32'(if0.dp_n),     32'h0);
    chk("pend_hold.seg1", 32'(if1.segments), 32'h40);
    frame_check("v2222",
                {7'h24, 7'h24, 7'h24, 7'h24}, 4'hF, 4'hF,
                {7'h24, 7'h24, 7'h24, 7'h24}, 4'hF, 4'hF);
    // Load sampled on the wrap edge goes straight into the following frame.
    load_at(14, 16'h3333, 4'h0);
    frame_check("v3333",
                {7'h30, 7'h30, 7'h30, 7'h30}, 4'hF, 4'hF,
                {7'h30, 7'h30, 7'h30, 7'h30}, 4'hF, 4'hF);
    frame_check("v3333b",
                {7'h30, 7'h30, 7'h30, 7'h30}, 4'hF, 4'hF,
                {7'h30, 7'h30, 7'h30, 7'h30}, 4'hF, 4'hF);

    // Blank: immediate on the next cycle, scanning keeps going.
    goto(1);
    drive(1'b0, 16'h0000, 4'h0, 1'b1);
    step();
    chk("blank.an0",  32'(if0.anode_n),  32'hF);
    chk("blank.seg0", 32'(if0.segments), 32'h7F);
    chk("blank.an1",  32'(if1.anode_n),  32'hF);
    chk("blank.seg1", 32'(if1.segments), 32'h7F);
    drive(1'b0, 16'h0000, 4'h0, 1'b0);
    step();
    chk("unblank.an0",  32'(if0.anode_n),  32'hE);
    chk("unblank.seg0", 32'(if0.segments), 32'h30);

    // 6. Reset during digit 2 slot with a load pending: pending is dropped.
    load_at(5, 16'h5555, 4'h0);
    goto(9);
    rst = 1'b1;
    track = 1'b0;
    step();
    reset_outputs("mid_rst");
    rst = 1'b0;
    cyc = -1;
    track = 1'b1;
    frame_check("post_rst_a",
                {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF, 4'hF,
                {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'h1, 4'hF);
    frame_check("post_rst_b",
                {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF, 4'hF,
                {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'h1, 4'hF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
